// File: rtl/relobi_encoder_monitored.sv
// Host-side OBI to relOBI encoder with Hsiao SECDED protection, TMR handshakes,
// outstanding-transaction flow control and sticky fault monitoring.
package relobi_encoder_monitored_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 1;

  // Smallest check width whose odd-weight (>=3) columns can cover k data bits.
  function automatic int unsigned ecc_width(int unsigned k);
    int unsigned width, n;
    width = 0;
    for (int unsigned r = 3; r <= 8; r++) begin
      n = 0;
      for (int unsigned v = 1; v < (32'd1 << r); v++)
        if ($countones(v) >= 3 && $countones(v) % 2 == 1) n++;
      if (width == 0 && n >= k) width = r;
    end
    return width;
  endfunction

  // Hsiao H-matrix columns: lowest odd weights first, ascending value within a weight.
  function automatic logic [63:0][7:0] hsiao_cols(int unsigned r);
    int unsigned n;
    hsiao_cols = '0;
    n = 0;
    for (int unsigned w = 3; w <= r; w += 2)
      for (int unsigned v = 1; v < (32'd1 << r); v++)
        if ($countones(v) == w && n < 64) begin
          hsiao_cols[n] = 8'(v);
          n++;
        end
  endfunction

  localparam int unsigned AddrEccWidth   = ecc_width(AddrWidth);
  localparam int unsigned DataEccWidth   = ecc_width(DataWidth);
  localparam int unsigned AOtherWidth    = 1 + DataWidth / 8 + IdWidth + 1;  // {a_optional, aid, be, we}
  localparam int unsigned AOtherEccWidth = ecc_width(AOtherWidth);
  localparam int unsigned ROtherWidth    = IdWidth + 2;                      // {r_optional, err, rid}
  localparam int unsigned ROtherEccWidth = ecc_width(ROtherWidth);

  typedef logic a_optional_t;
  typedef logic r_optional_t;

  typedef struct packed {
    logic                   req;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
    a_optional_t            a_optional;
    logic                   rready;
  } obi_req_t;

  typedef struct packed {
    logic                 gnt;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
    r_optional_t          r_optional;
  } obi_rsp_t;

  typedef struct packed {
    logic [2:0]                          req;
    logic [AddrWidth+AddrEccWidth-1:0]   addr;
    logic                                we;
    logic [DataWidth/8-1:0]              be;
    logic [DataWidth+DataEccWidth-1:0]   wdata;
    logic [IdWidth-1:0]                  aid;
    a_optional_t                         a_optional;
    logic [AOtherEccWidth-1:0]           other_ecc;
    logic [2:0]                          rready;
  } relobi_req_t;

  typedef struct packed {
    logic [2:0]                        gnt;
    logic [2:0]                        rvalid;
    logic [DataWidth+DataEccWidth-1:0] rdata;
    logic [IdWidth-1:0]                rid;
    logic                              err;
    r_optional_t                       r_optional;
    logic [ROtherEccWidth-1:0]         other_ecc;
  } relobi_rsp_t;
endpackage

module relobi_encoder_monitored_hsiao_enc #(
  parameter int unsigned K = 32,
  parameter int unsigned R = relobi_encoder_monitored_pkg::ecc_width(K)
) (
  input  logic [K-1:0] data,
  output logic [R-1:0] ecc
);
  localparam logic [63:0][7:0] HCols = relobi_encoder_monitored_pkg::hsiao_cols(R);

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    ecc = '0;
    for (int i = 0; i < K; i++) if (data[i]) ecc ^= HCols[i][R-1:0];
  end
endmodule

module relobi_encoder_monitored_hsiao_dec #(
  parameter int unsigned K = 32,
  parameter int unsigned R = relobi_encoder_monitored_pkg::ecc_width(K)
) (
  input  logic [K+R-1:0] code,
  output logic [K-1:0]   data,
  output logic [1:0]     err
);
  localparam logic [63:0][7:0] HCols = relobi_encoder_monitored_pkg::hsiao_cols(R);

  logic [R-1:0] syndrome;
  logic         hit;

  always_comb begin
    syndrome = code[K+R-1:K];
    for (int i = 0; i < K; i++) if (code[i]) syndrome ^= HCols[i][R-1:0];
  end

  // Even-weight syndromes never match a column, so they fall through to uncorrectable.
  always_comb begin
    data = code[K-1:0];
    hit  = 1'b0;
    for (int i = 0; i < K; i++)
      if (syndrome == HCols[i][R-1:0]) begin
        data[i] = ~code[i];
        hit     = 1'b1;
      end
    if (syndrome == '0)                 err = 2'b00;
    else if (hit || $onehot(syndrome))  err = 2'b01;
    else                                err = 2'b10;
  end
endmodule

module relobi_encoder_monitored
  import relobi_encoder_monitored_pkg::*;
#(
  parameter bit          UseRReady = 1'b1,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  obi_req_t                      req_i,
  output obi_rsp_t                      rsp_o,
  output relobi_req_t                   rel_req_o,
  input  relobi_rsp_t                   rel_rsp_i,
  output logic [$clog2(MaxTrans+1)-1:0] outstanding_o,
  output logic [4:0]                    err_status_o,
  output logic [CntWidth-1:0]           corr_cnt_o,
  output logic [CntWidth-1:0]           uncorr_cnt_o,
  output logic                          fault_o
);
  localparam int unsigned OutW = $clog2(MaxTrans + 1);

  function automatic logic maj3(logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic [AddrEccWidth-1:0]   addr_ecc;
  logic [DataEccWidth-1:0]   wdata_ecc;
  logic [AOtherEccWidth-1:0] a_other_ecc;
  logic [DataWidth-1:0]      rdata;
  logic [ROtherWidth-1:0]    r_other;
  logic [1:0]                rdata_err, r_other_err;
  logic full, req_out, gnt_voted, rvalid_voted, rready, acc, ret, corr_ev, uncorr_ev;
  logic [4:0] events;

  relobi_encoder_monitored_hsiao_enc #(.K(AddrWidth)) i_addr_enc (.data(req_i.addr), .ecc(addr_ecc));
  relobi_encoder_monitored_hsiao_enc #(.K(DataWidth)) i_wdata_enc (.data(req_i.wdata), .ecc(wdata_ecc));
  relobi_encoder_monitored_hsiao_enc #(.K(AOtherWidth)) i_a_other_enc (
    .data({req_i.a_optional, req_i.aid, req_i.be, req_i.we}), .ecc(a_other_ecc));
  relobi_encoder_monitored_hsiao_dec #(.K(DataWidth)) i_rdata_dec (
    .code(rel_rsp_i.rdata), .data(rdata), .err(rdata_err));
  relobi_encoder_monitored_hsiao_dec #(.K(ROtherWidth)) i_r_other_dec (
    .code({rel_rsp_i.other_ecc, rel_rsp_i.r_optional, rel_rsp_i.err, rel_rsp_i.rid}),
    .data(r_other), .err(r_other_err));

  assign full         = (outstanding_o == OutW'(MaxTrans));
  assign req_out      = req_i.req & ~full;
  assign gnt_voted    = maj3(rel_rsp_i.gnt);
  assign rvalid_voted = maj3(rel_rsp_i.rvalid);
  assign rready       = UseRReady ? req_i.rready : 1'b1;
  assign acc          = req_out & gnt_voted;
  assign ret          = rvalid_voted & rready;

  assign rel_req_o.req        = {3{req_out}};
  assign rel_req_o.addr       = {addr_ecc, req_i.addr};
  assign rel_req_o.we         = req_i.we;
  assign rel_req_o.be         = req_i.be;
  assign rel_req_o.wdata      = {wdata_ecc, req_i.wdata};
  assign rel_req_o.aid        = req_i.aid;
  assign rel_req_o.a_optional = req_i.a_optional;
  assign rel_req_o.other_ecc  = a_other_ecc;
  assign rel_req_o.rready     = {3{rready}};

  assign rsp_o.gnt        = gnt_voted & ~full;
  assign rsp_o.rvalid     = rvalid_voted;
  assign rsp_o.rdata      = rdata;
  assign rsp_o.rid        = r_other[IdWidth-1:0];
  assign rsp_o.err        = r_other[IdWidth];
  assign rsp_o.r_optional = r_other[IdWidth+1];

  // Any r-other decode error is treated as uncorrectable, even a single-bit one.
  assign events[0] = (rel_rsp_i.gnt != 3'b000) && (rel_rsp_i.gnt != 3'b111);
  assign events[1] = (rel_rsp_i.rvalid != 3'b000) && (rel_rsp_i.rvalid != 3'b111);
  assign events[2] = rvalid_voted & rdata_err[0];
  assign events[3] = rvalid_voted & (rdata_err[1] | (|r_other_err));
  assign events[4] = (ret & (outstanding_o == '0)) | (gnt_voted & ~req_out);
  assign corr_ev   = |events[2:0];
  assign uncorr_ev = |events[4:3];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
      err_status_o  <= '0;
      corr_cnt_o    <= '0;
      uncorr_cnt_o  <= '0;
      fault_o       <= 1'b0;
    end else begin
      if (acc && !ret && !full)                     outstanding_o <= outstanding_o + OutW'(1);
      else if (ret && !acc && outstanding_o != '0)  outstanding_o <= outstanding_o - OutW'(1);

      err_status_o <= (clear_i ? 5'b0 : err_status_o) | events;

      if (clear_i)                              corr_cnt_o <= CntWidth'(corr_ev);
      else if (corr_ev && corr_cnt_o != '1)     corr_cnt_o <= corr_cnt_o + CntWidth'(1);

      if (clear_i)                              uncorr_cnt_o <= CntWidth'(uncorr_ev);
      else if (uncorr_ev && uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);

      fault_o <= uncorr_ev;
    end
  end
endmodule

// File: tb/tb_relobi_encoder_monitored.sv
// Randomised and directed bench for relobi_encoder_monitored against a behavioural model
// built from Hsiao column definitions, majority votes and plain integer bookkeeping.
module tb_relobi_encoder_monitored;
  import relobi_encoder_monitored_pkg::*;

  localparam int MaxT = 4;
  localparam int CW   = 2;
  localparam int CMax = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear = 1'b0;
  obi_req_t    req;
  obi_rsp_t    rsp;
  relobi_req_t rel_req;
  relobi_rsp_t rel_rsp;
  logic [2:0]    outstanding;
  logic [4:0]    status;
  logic [CW-1:0] corr, uncorr;
  logic          fault;

  always #5 clk = ~clk;

  relobi_encoder_monitored #(.UseRReady(1'b1), .MaxTrans(MaxT), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .req_i(req), .rsp_o(rsp),
    .rel_req_o(rel_req), .rel_rsp_i(rel_rsp), .outstanding_o(outstanding),
    .err_status_o(status), .corr_cnt_o(corr), .uncorr_cnt_o(uncorr), .fault_o(fault));

  int total = 0;
  int bad = 0;

  // Staged stimulus, applied on the falling edge.
  obi_req_t    nx_req;
  logic        nx_clear;
  logic [2:0]  gnt_l, rv_l;
  logic [31:0] rdata_val;
  logic        rid_v, err_v, ropt_v;
  int          rflips, oflips;

  // Model state and per-cycle model results.
  int         m_out, m_corr, m_uncorr;
  logic [4:0] m_status, m_ev;
  logic       m_fault, m_acc, m_ret;
  obi_rsp_t    snap_rsp;
  relobi_req_t snap_req;

  logic [7:0] col_tab [9][64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] tb_ecc(input logic [63:0] d, input int k, input int r);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < k; i++) if (d[i]) e ^= col_tab[r][i];
    return e;
  endfunction

  task automatic idle();
    nx_req = '0;
    nx_req.rready = 1'b1;
    nx_clear = 1'b0;
    gnt_l = 3'b000;
    rv_l = 3'b000;
    rflips = 0;
    oflips = 0;
    rdata_val = $urandom;
    {rid_v, err_v, ropt_v} = 3'($urandom_range(0, 7));
  endtask

  task automatic apply();
    logic [7:0]  e;
    logic [38:0] cw;
    logic [6:0]  ow;
    logic [2:0]  ov;
    int p;
    req = nx_req;
    clear = nx_clear;
    e = tb_ecc(64'(rdata_val), 32, 7);
    cw = {e[6:0], rdata_val};
    if (rflips > 0) begin
      p = $urandom_range(0, 38);
      cw[p] = ~cw[p];
      if (rflips > 1) begin
        p = (p + $urandom_range(1, 38)) % 39;
        cw[p] = ~cw[p];
      end
    end
    ov = {ropt_v, err_v, rid_v};
    e = tb_ecc(64'(ov), 3, 4);
    ow = {e[3:0], ov};
    if (oflips > 0) begin
      p = $urandom_range(0, 6);
      ow[p] = ~ow[p];
      if (oflips > 1) begin
        p = (p + $urandom_range(1, 6)) % 7;
        ow[p] = ~ow[p];
      end
    end
    rel_rsp.gnt        = gnt_l;
    rel_rsp.rvalid     = rv_l;
    rel_rsp.rdata      = cw;
    rel_rsp.rid        = ow[0];
    rel_rsp.err        = ow[1];
    rel_rsp.r_optional = ow[2];
    rel_rsp.other_ecc  = ow[6:3];
  endtask

  task automatic compare();
    logic [7:0] e;
    logic full, req_out, gv, rvv;
    full    = (m_out == MaxT);
    req_out = req.req && !full;
    gv      = $countones(rel_rsp.gnt) >= 2;
    rvv     = $countones(rel_rsp.rvalid) >= 2;
    m_acc   = req_out && gv;
    m_ret   = rvv && req.rready;
    m_ev[0] = (rel_rsp.gnt != 3'b000) && (rel_rsp.gnt != 3'b111);
    m_ev[1] = (rel_rsp.rvalid != 3'b000) && (rel_rsp.rvalid != 3'b111);
    m_ev[2] = rvv && (rflips == 1);
    m_ev[3] = rvv && (rflips == 2 || oflips != 0);
    m_ev[4] = (m_ret && m_out == 0) || (gv && !req_out);

    check("req_lanes", 64'(rel_req.req), req_out ? 64'd7 : 64'd0);
    check("rready_lanes", 64'(rel_req.rready), 64'({3{req.rready}}));
    e = tb_ecc(64'(req.addr), 32, 7);
    check("addr_code", 64'(rel_req.addr), 64'({e[6:0], req.addr}));
    e = tb_ecc(64'(req.wdata), 32, 7);
    check("wdata_code", 64'(rel_req.wdata), 64'({e[6:0], req.wdata}));
    e = tb_ecc(64'({req.a_optional, req.aid, req.be, req.we}), 7, 5);
    check("a_fields", 64'({rel_req.a_optional, rel_req.aid, rel_req.be, rel_req.we, rel_req.other_ecc}),
          64'({req.a_optional, req.aid, req.be, req.we, e[4:0]}));
    check("gnt", 64'(rsp.gnt), 64'(gv && !full));
    check("rvalid", 64'(rsp.rvalid), 64'(rvv));
    if (rflips < 2) check("rdata", 64'(rsp.rdata), 64'(rdata_val));
    if (oflips < 2) check("r_fields", 64'({rsp.r_optional, rsp.err, rsp.rid}), 64'({ropt_v, err_v, rid_v}));
    check("outstanding", 64'(outstanding), 64'(m_out));
    check("status", 64'(status), 64'(m_status));
    check("corr_cnt", 64'(corr), 64'(m_corr));
    check("uncorr_cnt", 64'(uncorr), 64'(m_uncorr));
    check("fault", 64'(fault), 64'(m_fault));
    snap_rsp = rsp;
    snap_req = rel_req;
  endtask

  task automatic model_update();
    logic ce, ue;
    ce = |m_ev[2:0];
    ue = |m_ev[4:3];
    if (m_acc && !m_ret) m_out++;
    else if (m_ret && !m_acc && m_out > 0) m_out--;
    m_status = (clear ? 5'b0 : m_status) | m_ev;
    m_corr   = clear ? int'(ce) : (ce ? ((m_corr < CMax) ? m_corr + 1 : CMax) : m_corr);
    m_uncorr = clear ? int'(ue) : (ue ? ((m_uncorr < CMax) ? m_uncorr + 1 : CMax) : m_uncorr);
    m_fault  = ue;
  endtask

  task automatic model_reset();
    m_out = 0; m_corr = 0; m_uncorr = 0; m_status = '0; m_fault = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    apply();
    #1 compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    for (int r = 3; r <= 8; r++) begin
      int n;
      n = 0;
      for (int w = 3; w <= r; w += 2)
        for (int v = 1; v < (1 << r); v++)
          if ($countones(v) == w && n < 64) begin
            col_tab[r][n] = 8'(v);
            n++;
          end
    end
    model_reset();
    idle();
    apply();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    step();
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_status", 64'(status), 64'd0);
    check("reset_counters", 64'({corr, uncorr, fault}), 64'd0);

    // Fill to MaxTrans, stall, retire one, resume.
    idle(); nx_req.req = 1'b1; nx_req.addr = 32'h1; gnt_l = 3'b111;
    repeat (4) step();
    check("fill_outstanding", 64'(outstanding), 64'd4);
    check("addr_code_literal", 64'(snap_req.addr), 64'h07_0000_0001);
    gnt_l = 3'b000; step();
    check("full_req_lanes", 64'(snap_req.req), 64'd0);
    check("full_gnt", 64'(snap_rsp.gnt), 64'd0);
    nx_req.req = 1'b0; rv_l = 3'b111; step();
    check("retire_outstanding", 64'(outstanding), 64'd3);
    rv_l = 3'b000; nx_req.req = 1'b1; gnt_l = 3'b111; step();
    check("resume_gnt", 64'(snap_rsp.gnt), 64'd1);
    check("resume_outstanding", 64'(outstanding), 64'd4);
    check("clean_status", 64'(status), 64'd0);

    idle(); rv_l = 3'b111; repeat (4) step();
    check("drained", 64'(outstanding), 64'd0);

    // Single-lane grant fault: masked, reported as correctable.
    idle(); nx_req.req = 1'b1; gnt_l = 3'b110; step();
    check("gnt_vote_gnt", 64'(snap_rsp.gnt), 64'd1);
    check("gnt_vote_outstanding", 64'(outstanding), 64'd1);
    check("gnt_vote_status", 64'(status), 64'b00001);
    check("gnt_vote_corr", 64'(corr), 64'd1);
    check("gnt_vote_fault", 64'(fault), 64'd0);

    // One flipped rdata bit corrected, then a double flip.
    idle(); rv_l = 3'b111; rflips = 1; rdata_val = 32'hDEAD_BEEF; step();
    check("corrected_rdata", 64'(snap_rsp.rdata), 64'hDEAD_BEEF);
    check("corrected_corr", 64'(corr), 64'd2);
    check("corrected_status", 64'(status), 64'b00101);
    idle(); nx_req.req = 1'b1; gnt_l = 3'b111; step();
    idle(); rv_l = 3'b111; rflips = 2; step();
    check("double_status", 64'(status), 64'b01101);
    check("double_uncorr", 64'(uncorr), 64'd1);
    check("double_fault", 64'(fault), 64'd1);
    idle(); step();
    check("fault_pulse_ends", 64'(fault), 64'd0);

    // Retire with nothing outstanding.
    idle(); nx_clear = 1'b1; step();
    idle(); rv_l = 3'b111; step();
    check("orphan_status", 64'(status), 64'b10000);
    check("orphan_outstanding", 64'(outstanding), 64'd0);
    check("orphan_fault", 64'(fault), 64'd1);

    // Counter saturation and clear-with-event.
    idle(); nx_clear = 1'b1; step();
    idle(); rv_l = 3'b001; repeat (5) step();
    check("sat_corr", 64'(corr), 64'd3);
    nx_clear = 1'b1; step();
    check("clear_event_corr", 64'(corr), 64'd1);
    check("clear_event_status", 64'(status), 64'b00010);
    check("clear_event_uncorr", 64'(uncorr), 64'd0);

    // Asynchronous reset mid-burst.
    idle(); nx_req.req = 1'b1; gnt_l = 3'b111; repeat (2) step();
    check("burst_outstanding", 64'(outstanding), 64'd2);
    @(negedge clk);
    idle(); apply();
    #3 rst_ni = 1'b0;
    #1;
    check("async_outstanding", 64'(outstanding), 64'd0);
    check("async_status", 64'(status), 64'd0);
    check("async_counters", 64'({corr, uncorr, fault}), 64'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    idle(); rv_l = 3'b111; step();
    check("post_reset_status", 64'(status), 64'b10000);
    check("post_reset_fault", 64'(fault), 64'd1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic g, v;
      nx_req.req        = $urandom_range(0, 3) != 0;
      nx_req.addr       = $urandom;
      nx_req.we         = 1'($urandom_range(0, 1));
      nx_req.be         = 4'($urandom_range(0, 15));
      nx_req.wdata      = $urandom;
      nx_req.aid        = 1'($urandom_range(0, 1));
      nx_req.a_optional = 1'($urandom_range(0, 1));
      nx_req.rready     = $urandom_range(0, 4) != 0;
      g = (nx_req.req && m_out < MaxT) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      gnt_l = {3{g}};
      if ($urandom_range(0, 9) == 0) gnt_l[$urandom_range(0, 2)] ^= 1'b1;
      v = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rv_l = {3{v}};
      if ($urandom_range(0, 9) == 0) rv_l[$urandom_range(0, 2)] ^= 1'b1;
      rdata_val = $urandom;
      {rid_v, err_v, ropt_v} = 3'($urandom_range(0, 7));
      rflips = $urandom_range(0, 9);
      rflips = (rflips < 7) ? 0 : ((rflips < 9) ? 1 : 2);
      oflips = $urandom_range(0, 19);
      oflips = (oflips < 17) ? 0 : ((oflips < 19) ? 1 : 2);
      nx_clear = $urandom_range(0, 9) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/relobi_encoder_monitored.md
Name: relobi_encoder_monitored

Overview:
Host-side OBI-to-relOBI encoder that triplicates request handshakes, Hsiao-encodes addr/wdata, votes grant/rvalid and decodes rdata. It also tracks outstanding transactions with flow control and turns every detected fault into sticky status, saturating counters and a fault pulse. It sits between a core-side OBI manager and the reliable interconnect, and it replaces the plain encoder where error reporting is required.

Parameters:
Cfg, obi_pkg::ObiDefaultConfig, bus configuration (AddrWidth, DataWidth, UseRReady, ...)
relobi_req_t / relobi_rsp_t / obi_req_t / obi_rsp_t, logic, bus struct types
a_optional_t / r_optional_t, logic, optional-field types
MaxTrans, 4, maximum outstanding transactions (>=1)
CntWidth, 8, width of each error counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of status and counters
req_i  in  obi_req_t  host request
rsp_o  out  obi_rsp_t  host response (voted/decoded)
rel_req_o  out  relobi_req_t  reliable request
rel_rsp_i  in  relobi_rsp_t  reliable response
outstanding_o  out  $clog2(MaxTrans+1)  current outstanding count
err_status_o  out  5  sticky flags [0] gnt vote mismatch, [1] rvalid vote mismatch, [2] rdata correctable, [3] rdata/r-other uncorrectable, [4] protocol violation
corr_cnt_o  out  CntWidth  correctable event count
uncorr_cnt_o  out  CntWidth  uncorrectable event count
fault_o  out  1  registered pulse on any uncorrectable event

Behaviour:
- Datapath is combinational, zero latency: addr/wdata Hsiao-encoded; we/be/aid/a_optional passed through with other_ecc generated; rdata Hsiao-decoded; rid/err/r_optional decoded via other_ecc. rready is triplicated when Cfg.UseRReady.
- The decoder error vector has [0] = correctable and [1] = uncorrectable. r-other decode errors count as uncorrectable.
- Accept: acc = req_o_int & gnt_voted. Retire: ret = rvalid_voted & (rready | !UseRReady).
- Flow control: full = (outstanding == MaxTrans). When full, rel_req_o.req = 3'b000 and rsp_o.gnt = 0. Otherwise req is replicated {3{req_i.req}}.
- Outstanding counter:
  - +1 on acc only; -1 on ret only; unchanged on both or neither.
  - Saturates at 0 and at MaxTrans; never wraps.
- Per-cycle events:
  - E0: the three gnt copies disagree.
  - E1: the three rvalid copies disagree.
  - E2: correctable decode while rvalid_voted.
  - E3: uncorrectable decode while rvalid_voted.
  - E4: ret while outstanding == 0, or gnt_voted while the outgoing req is 0.
- Decode errors are ignored when rvalid_voted = 0.
- err_status_o:
  - Bit k is set the cycle after Ek and held until clear_i.
  - If clear_i and Ek occur in the same cycle, the bit is set (set wins).
- Counters:
  - corr_cnt_o increments by 1 per cycle in which any of E0/E1/E2 occurs.
  - uncorr_cnt_o increments by 1 per cycle in which E3 or E4 occurs.
  - Both saturate at all-ones.
  - clear_i zeroes a counter; clear_i plus an event in the same cycle loads 1.
- fault_o = registered (E3 | E4): high exactly one cycle after each such cycle; consecutive events keep it high.
- Reset (async, rst_ni=0): outstanding, status, counters and fault_o all go to 0 immediately. In-flight transactions are dropped, and a post-reset rvalid is flagged as E4.
- Voting is majority, so a single-lane fault is masked on rsp_o but still reported.

Test Plan:
- MaxTrans=4, issue 4 granted requests with no rvalid -> outstanding_o=4; 5th req: rel_req_o.req=000, rsp_o.gnt=0. One retire -> outstanding_o=3, gnt resumes.
- gnt lanes 3'b110 with req=1 -> rsp_o.gnt=1, accepted; err_status_o[0]=1 next cycle; corr_cnt_o=1; fault_o stays 0.
- rvalid with 1 flipped rdata bit -> corrected rdata on rsp_o, corr_cnt_o+1. With 2 flipped bits -> err_status_o[3]=1, uncorr_cnt_o+1, fault_o high one cycle.
- rvalid=3'b111 with outstanding=0 -> err_status_o[4]=1, outstanding_o stays 0, fault_o pulse.
- CntWidth=2, 5 correctable events -> corr_cnt_o=3. clear_i together with an event -> corr_cnt_o=1 and that event's status bit set.
- rst_ni low mid-burst with outstanding=2 -> all outputs 0 asynchronously. After release, one rvalid -> E4 flagged.
